// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every request is DIVU.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag1, mag2;
    logic [31:0] quo_fix, rem_fix;

    // One restoring step: shift, trial-subtract, keep the difference if no borrow.
    logic [64:0] shifted;
    logic [33:0] trial;
    logic [64:0] step;

    assign shifted = {work_q[63:0], 1'b0};
    assign trial   = {1'b0, shifted[64:32]} - {2'b00, dvsr_q};
    assign step    = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic dvd_neg, dvs_neg;

    assign dvd_neg = signed_i & opdata1_i[31];
    assign dvs_neg = signed_i & opdata2_i[31];
    assign mag1    = dvd_neg ? -opdata1_i : opdata1_i;
    assign mag2    = dvs_neg ? -opdata2_i : opdata2_i;
    assign quo_fix = qneg_q ? -step[31:0]  : step[31:0];
    assign rem_fix = rneg_q ? -step[63:32] : step[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == S_IDLE && !annul_i && start_i) begin
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign mag1          = opdata1_i;
    assign mag2          = opdata2_i;
    assign quo_fix       = step[31:0];
    assign rem_fix       = step[63:32];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Next state: annul_i wins over start_i everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!annul_i && start_i)
                    state_d = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (annul_i)
                    state_d = S_IDLE;
                else if (cnt_q == 5'd31)
                    state_d = S_END;
            end
            S_END: begin
                if (annul_i || !start_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (!annul_i && start_i && opdata2_i != 32'd0) begin
                    cnt_d  = '0;
                    work_d = {33'd0, mag1};
                    dvsr_d = mag2;
                end
            end
            S_BYZERO: begin
                result_d = '0;
                ready_d  = !annul_i;
            end
            S_ON: begin
                if (annul_i) begin
                    cnt_d  = '0;
                    work_d = '0;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divider sequencer for the EX stage. It accepts a DIV/DIVU request, runs a 32-iteration radix-2 restoring division, and holds the pipeline through the stall request it raises. It then presents the {remainder, quotient} pair for the HI/LO write that travels through MEM and WB. It is the only block that produces HI/LO values for division. It owns the divide datapath and its sequencing.

## Interface

Parameters:
- none (operand width fixed at 32)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-low reset
- start_i  input  1  division requested by the instruction in EX; held high until that instruction leaves EX
- signed_i  input  1  1 = DIV, 0 = DIVU; sampled with start_i in IDLE
- opdata1_i  input  32  dividend; sampled in IDLE
- opdata2_i  input  32  divisor; sampled in IDLE
- annul_i  input  1  flush of the EX instruction; cancels the operation
- result_o  output  64  {remainder[63:32] to HI, quotient[31:0] to LO}
- ready_o  output  1  result_o valid
- stallreq_o  output  1  stall request to the pipeline controller

## Operation

FSM states are IDLE, BYZERO, ON and END.

- **IDLE**
  - If annul_i=1, stay in IDLE.
  - Else if start_i=1 and opdata2_i=0, go to BYZERO.
  - Else if start_i=1, latch the operands and signed_i, clear the counter, and go to ON.
- **BYZERO**
  - Next cycle, go to END with result 64'h0. The MIPS result is undefined here; this block defines it as 0.
- **ON**
  - Each cycle performs one shift-subtract step on a 65-bit working register {partial remainder, dividend}.
  - The counter runs 0..31; after step 31, go to END.
  - If annul_i=1, go to IDLE and discard the working register.
- **END**
  - ready_o=1 and result_o holds the result.
  - Stay in END while start_i=1.
  - When start_i=0, go to IDLE; ready_o drops and result_o clears to 0.

Signed handling when signed_i=1:
- Operands are converted to magnitudes at latch.
- The quotient is negated if the operand signs differ.
- The remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).

Stall and priority rules:
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
- annul_i has priority over start_i in every state.
- In END, annul_i forces a transition to IDLE.
- A new start_i is accepted only from IDLE. Back-to-back divides need one IDLE cycle, which is guaranteed because the EX instruction changes.

## Timing

Reset (rst=0, asynchronous):
- State goes to IDLE; counter and working register clear.
- result_o=0, ready_o=0.
- stallreq_o follows its combinational equation.

Latency, with cycle 0 being the first edge at which start_i=1 is seen in IDLE:
- Nonzero divisor: ON for cycles 1..32; ready_o=1 from cycle 33.
- Zero divisor: BYZERO in cycle 1; ready_o=1 from cycle 2.

Output timing:
- ready_o and result_o are registered.
- The HI/LO write is taken by EX in the first cycle with ready_o=1, when stallreq_o falls.

Reset mid-operation: abort immediately to IDLE; no partial result is ever presented.

## Configuration

Macro: DIV_SIGNED_EN.
- Defined: signed_i is honoured as described in Operation.
- Undefined: the sign-conversion logic is removed and signed_i is ignored. Every request is computed as DIVU, with the same latency.

## Test plan

- **Unsigned divide:** DIVU 100 / 7, start held. Required: stallreq_o=1 for cycles 0..32; ready_o=1 at cycle 33; result_o = {32'd2, 32'd14}; drop start_i and check IDLE with result_o=0 next cycle.
- **Signed divide** (DIV_SIGNED_EN defined):
  - -7 / 2 gives {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - 7 / -2 gives {32'd1, 32'hFFFFFFFD}.
  - 0x80000000 / -1 gives {32'h0, 32'h80000000}.
- **Divide by zero:** 5 / 0. Required: ready_o=1 at cycle 2; result_o = 64'h0; stallreq_o=1 in cycles 0..1 only.
- **Annul:** assert annul_i at cycle 10 of ON. Required: IDLE next cycle; ready_o never rises; stallreq_o=0 during annul_i. A following start then completes normally in 33 cycles.
- **Reset mid-operation:** pull rst low at cycle 20. Required: IDLE asynchronously; result_o=0 and ready_o=0. After release, a new 100/7 completes correctly.
- **Unsigned build:** with DIV_SIGNED_EN undefined, DIV of 0xFFFFFFF9 / 2 gives {32'd1, 32'h7FFFFFFC}.
